// File: rtl/sense_reader.sv
// sense_reader: capture delay-line sensor words, encode, buffer, drain as bytes.
// Define SENSE_READER_LEADONE_EN for leading-ones encoding instead of popcount.
module sense_reader #(
  parameter int LINELEN  = 64,
  parameter int NSAMPLES = 256,
  parameter int ADDRW    = 8
) (
  input  logic               clkin,
  input  logic               rstnin,
  input  logic [LINELEN-1:0] valin,
  input  logic               trigin,
  output logic [7:0]         tdata,
  output logic               tvalid,
  input  logic               tready,
  output logic               busyout
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CAPTURE,
    S_FLUSH,
    S_DRAIN
  } state_t;

  localparam int DEPTH = 1 << ADDRW;
  localparam logic [ADDRW:0] NS  = (ADDRW+1)'(NSAMPLES);
  localparam logic [ADDRW:0] ONE = (ADDRW+1)'(1);

  state_t             state_q, state_d;
  logic [LINELEN-1:0] s1_q, s1_d;
  logic               s1_vld_q, s1_vld_d;
  logic [ADDRW:0]     ld_cnt_q, ld_cnt_d;
  logic [ADDRW:0]     wptr_q, wptr_d;
  logic [ADDRW:0]     rptr_q, rptr_d;
  logic [7:0]         tdata_q, tdata_d;
  logic               tvalid_q, tvalid_d;
  logic               busy_q, busy_d;
  logic [7:0]         enc;
  logic               load;
  logic               we;
  logic               accept;
  logic [7:0]         mem [DEPTH];

  // Stage-2 encoder of the registered sensor word.
`ifdef SENSE_READER_LEADONE_EN
  always_comb begin
    logic run;
    run = 1'b1;
    enc = '0;
    for (int i = 0; i < LINELEN; i++) begin
      run = run & s1_q[i];
      enc = enc + 8'(run);
    end
  end
`else
  always_comb begin
    enc = '0;
    for (int i = 0; i < LINELEN; i++) begin
      enc = enc + 8'(s1_q[i]);
    end
  end
`endif

  // Next-state for the FSM, pipeline, pointers and stream outputs.
  always_comb begin
    state_d  = state_q;
    ld_cnt_d = ld_cnt_q;
    wptr_d   = wptr_q;
    rptr_d   = rptr_q;
    tdata_d  = tdata_q;
    tvalid_d = tvalid_q;
    busy_d   = busy_q;
    load     = (state_q == S_CAPTURE)
             && (ld_cnt_q != NS);
    we       = s1_vld_q;
    accept   = tvalid_q && tready;
    s1_d     = load ? valin : s1_q;
    s1_vld_d = load;
    if (we) begin
      wptr_d = wptr_q + ONE;
    end
    unique case (state_q)
      S_IDLE: begin
        if (trigin) begin
          state_d  = S_CAPTURE;
          ld_cnt_d = '0;
          wptr_d   = '0;
          busy_d   = 1'b1;
        end
      end
      S_CAPTURE: begin
        if (load) begin
          ld_cnt_d = ld_cnt_q + ONE;
        end
        if (we && (wptr_q == NS - ONE)) begin
          state_d = S_FLUSH;
        end
      end
      S_FLUSH: begin
        state_d = S_DRAIN;
        rptr_d  = '0;
      end
      S_DRAIN: begin
        if (accept && (rptr_q == NS)) begin
          tvalid_d = 1'b0;
          busy_d   = 1'b0;
          state_d  = S_IDLE;
        end else if ((!tvalid_q || accept)
                     && (rptr_q != NS)) begin
          tdata_d  = mem[rptr_q[ADDRW-1:0]];
          tvalid_d = 1'b1;
          rptr_d   = rptr_q + ONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Control and output registers; reset discards any capture in flight.
  always_ff @(posedge clkin or negedge rstnin) begin
    if (!rstnin) begin
      state_q  <= S_IDLE;
      s1_q     <= '0;
      s1_vld_q <= 1'b0;
      ld_cnt_q <= '0;
      wptr_q   <= '0;
      rptr_q   <= '0;
      tdata_q  <= '0;
      tvalid_q <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      s1_q     <= s1_d;
      s1_vld_q <= s1_vld_d;
      ld_cnt_q <= ld_cnt_d;
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      tdata_q  <= tdata_d;
      tvalid_q <= tvalid_d;
      busy_q   <= busy_d;
    end
  end

  // Sample buffer; contents survive reset, pointers make them stale.
  always_ff @(posedge clkin) begin
    if (we) begin
      mem[wptr_q[ADDRW-1:0]] <= enc;
    end
  end

  assign tdata   = tdata_q;
  assign tvalid  = tvalid_q;
  assign busyout = busy_q;

endmodule

// File: tb/tb_sense_reader.sv
// tb_sense_reader: random and directed captures checked against a
// behavioural byte-queue model of the sensor reader.
module tb_sense_reader;

  localparam int NS = 4;

  logic        clk = 1'b0;
  logic        rstn;
  logic [63:0] valin;
  logic        trig;
  logic [7:0]  tdata;
  logic        tvalid;
  logic        tready;
  logic        busyout;

  int n_chk = 0;
  int n_pass = 0;
  int rdy_mode = 0;
  int rdy_ph = 0;
  int exp_q[$];
  logic [63:0] words [NS];
  int expv [NS];
  logic prev_v;
  logic [7:0] prev_d;

  sense_reader #(
    .LINELEN(64),
    .NSAMPLES(NS),
    .ADDRW(2)
  ) dut (
    .clkin(clk),
    .rstnin(rstn),
    .valin(valin),
    .trigin(trig),
    .tdata(tdata),
    .tvalid(tvalid),
    .tready(tready),
    .busyout(busyout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  function automatic int enc(input logic [63:0] w);
`ifdef SENSE_READER_LEADONE_EN
    int n;
    n = 0;
    for (int i = 0; i < 64; i++) begin
      if (!w[i]) break;
      n++;
    end
    return n;
`else
    return $countones(w);
`endif
  endfunction

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  function automatic logic [63:0] rnd_word();
    int p;
    logic [63:0] w;
    p = $urandom_range(0, 64);
    w = (p == 64) ? '1 : ((64'd1 << p) - 64'd1);
    if ($urandom_range(0, 3) == 0) w[$urandom_range(0, 63)] ^= 1'b1;
    if ($urandom_range(0, 7) == 0) w = rnd64();
    return w;
  endfunction

  // Downstream ready pattern: always, 1-0-0-1 cycle, or random.
  initial begin
    tready = 1'b0;
    forever begin
      @(negedge clk);
      #1;
      case (rdy_mode)
        0: tready = 1'b1;
        1: tready = (rdy_ph % 4 == 0) || (rdy_ph % 4 == 3);
        default: tready = 1'($urandom_range(0, 1));
      endcase
      rdy_ph++;
    end
  end

  // Stream monitor: every accepted byte must be the model's next byte,
  // and a stalled byte must hold.
  initial begin
    int e;
    prev_v = 1'b0;
    prev_d = '0;
    forever begin
      @(posedge clk);
      #1;
      if (!rstn) begin
        prev_v = 1'b0;
        continue;
      end
      if (prev_v) begin
        if (tready) begin
          if (exp_q.size() == 0) chk("extra_byte", 1, 0);
          else begin
            e = exp_q.pop_front();
            chk("byte", prev_d, e);
          end
        end else begin
          chk("hold_valid", tvalid, 1);
          chk("hold_data", tdata, prev_d);
        end
      end else if (tvalid) begin
        chk("valid_with_data_due", exp_q.size() > 0, 1);
      end
      if (tvalid) chk("valid_while_busy", busyout, 1);
      prev_v = tvalid;
      prev_d = tdata;
    end
  end

  task automatic fill_model();
    for (int k = 0; k < NS; k++) expv[k] = enc(words[k]);
  endtask

  task automatic capture(input bit pulse);
    int first;
    int done;
    for (int k = 0; k < NS; k++) exp_q.push_back(expv[k]);
    @(negedge clk);
    #1;
    trig = 1'b1;
    valin = rnd64();
    @(posedge clk);
    #1;
    chk("busy_at_trigger", busyout, 1);
    first = 0;
    done = 0;
    for (int i = 1; i <= 300 && done == 0; i++) begin
      @(negedge clk);
      #1;
      trig = pulse && (i == 2 || i == NS + 5);
      valin = (i <= NS) ? words[i-1] : rnd64();
      @(posedge clk);
      #2;
      if (tvalid && first == 0) first = i;
      if (!busyout) done = i;
    end
    trig = 1'b0;
    chk("capture_ended", done != 0, 1);
    chk("first_valid_edge", first, NS + 3);
    if (rdy_mode == 0) chk("capture_to_idle", done, 2 * NS + 3);
    chk("all_bytes_out", exp_q.size(), 0);
    repeat (3) @(posedge clk);
    #1;
    chk("stay_idle", busyout, 0);
  endtask

  initial begin
    rstn = 1'b0;
    trig = 1'b0;
    valin = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    rstn = 1'b1;

    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      chk("idle_tvalid", tvalid, 0);
      chk("idle_busy", busyout, 0);
      chk("idle_tdata", tdata, 0);
    end

    chk("model_zero", enc(64'h0), 0);
    chk("model_full", enc('1), 64);
`ifdef SENSE_READER_LEADONE_EN
    chk("model_bubble", enc(64'hF7), 3);
`else
    chk("model_bubble", enc(64'hF7), 7);
`endif

    rdy_mode = 0;
    words[0] = 64'h0;
    words[1] = 64'hFF;
    words[2] = 64'hFFFF_FFFF;
    words[3] = '1;
    expv[0] = 8'h00;
    expv[1] = 8'h08;
    expv[2] = 8'h20;
    expv[3] = 8'h40;
    capture(1'b0);

    for (int k = 0; k < NS; k++) begin
      words[k] = 64'hF7;
`ifdef SENSE_READER_LEADONE_EN
      expv[k] = 3;
`else
      expv[k] = 7;
`endif
    end
    capture(1'b0);

    rdy_mode = 1;
    for (int k = 0; k < NS; k++) words[k] = rnd_word();
    fill_model();
    capture(1'b0);

    rdy_mode = 0;
    for (int k = 0; k < NS; k++) words[k] = rnd_word();
    fill_model();
    capture(1'b1);

    for (int k = 0; k < NS; k++) words[k] = rnd_word();
    fill_model();
    for (int k = 0; k < NS; k++) exp_q.push_back(expv[k]);
    @(negedge clk);
    #1;
    trig = 1'b1;
    for (int i = 0; i < NS; i++) begin
      @(negedge clk);
      #1;
      trig = 1'b0;
      valin = words[i];
    end
    for (int c = 0; c < 100 && exp_q.size() > 2; c++) begin
      @(posedge clk);
      #2;
    end
    chk("two_accepted", exp_q.size(), 2);
    chk("valid_before_reset", tvalid, 1);
    @(negedge clk);
    #1;
    rstn = 1'b0;
    #1;
    chk("reset_tvalid", tvalid, 0);
    chk("reset_busy", busyout, 0);
    chk("reset_tdata", tdata, 0);
    exp_q.delete();
    @(negedge clk);
    #1;
    rstn = 1'b1;
    for (int k = 0; k < NS; k++) words[k] = rnd_word();
    fill_model();
    capture(1'b0);

    for (int r = 0; r < 20; r++) begin
      rdy_mode = $urandom_range(0, 2);
      for (int k = 0; k < NS; k++) words[k] = rnd_word();
      fill_model();
      capture(1'($urandom_range(0, 1)));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/sense_reader.md
# sense_reader

Capture-side consumer of the 64-tap carry-chain delay-line sensor. It samples the sensor's thermometer-coded output word on every clock during a triggered capture window and encodes each word to an 8-bit delay value. It stores a fixed number of samples in an on-chip buffer, then drains them in order over a valid/ready byte stream toward the host link (UART/trace path). It sits between the sensor line registers and the readout logic in the power-analysis capture chain.

## Interface
- `LINELEN`, default 64: sensor line width in taps; must be ≤ 255.
- `NSAMPLES`, default 256: samples stored per capture; must be ≤ 2^`ADDRW`.
- `ADDRW`, default 8: buffer address width.

- `clkin` in 1: single clock; the same clock that drives the sensor.
- `rstnin` in 1: asynchronous, active-low reset.
- `valin` in `LINELEN`: sensor thermometer word, updated on the falling edge of `clkin`.
- `trigin` in 1: capture request; level-sampled on the rising edge.
- `tdata` out 8: encoded sample byte.
- `tvalid` out 1: `tdata` valid.
- `tready` in 1: downstream accepts the byte.
- `busyout` out 1: high in every state except IDLE.

## Operation
- **Input pipeline:** stage 1 registers `valin` on the rising edge (half-cycle path from the sensor). Stage 2 encodes and writes the buffer. Encode latency is 2 cycles.
- **Encoding:** number of ones in the stage-1 word, range 0..`LINELEN`, zero-extended to 8 bits. This count is bubble-tolerant.
- **Buffer:** single-port-write, registered-read RAM of 2^`ADDRW` × 8, plus write and read pointers of `ADDRW`+1 bits.
- **FSM states:** IDLE, CAPTURE, FLUSH, DRAIN.
  - **IDLE:** `trigin`=1 at an edge → CAPTURE, and write counter cleared.
  - **CAPTURE:** each cycle, the stage-2 result is written at the write counter, which then increments. At the last stage-1 load (`NSAMPLES` loads issued) → FLUSH.
  - **FLUSH:** one cycle to retire the final pipelined sample. Then read pointer cleared → DRAIN.
  - **DRAIN:** presents samples in write order. After the byte at index `NSAMPLES`-1 is accepted → IDLE.
- **Stream rules:**
  - `tvalid` rises only in DRAIN.
  - Once high, `tvalid` and `tdata` remain stable until a cycle with `tvalid`&&`tready`.
  - After acceptance, the next byte is presented in the following cycle (one byte per cycle sustained when `tready`=1).
  - `tready` while `tvalid`=0 is ignored.
- **Boundary conditions:**
  - `trigin` while busy is ignored. It is not queued.
  - `trigin` held high re-arms immediately after returning to IDLE.
  - `valin` is all zeros → 0x00. `valin` is all ones → `LINELEN` (0x40).
  - The write counter never exceeds `NSAMPLES`. No overflow is possible because capture and drain never overlap.
  - `rstnin` low at any time, mid-capture or mid-drain:
    - Immediately forces IDLE.
    - Clears the pointers and pipeline valid flags.
    - Discards the buffer contents logically.
    - The RAM contents themselves are not cleared.

## Timing
- **Reset values:** `tdata`=0x00, `tvalid`=0, `busyout`=0, state IDLE.
- **Capture start:**
  - `trigin` sampled at edge T.
  - `busyout`=1 from T.
  - Stage-1 loads at edges T+1 … T+`NSAMPLES`.
  - Buffer writes at T+2 … T+`NSAMPLES`+1.
- **FLUSH** occupies edge T+`NSAMPLES`+1. DRAIN is entered at T+`NSAMPLES`+2.
- **First byte:** `tvalid`=1 first at edge T+`NSAMPLES`+3, after the registered RAM read.
- **Drain end:** the final handshake at edge E gives `tvalid`=0 and `busyout`=0 after E. A new `trigin` is sampled at E+1 at the earliest.
- **Minimum capture-to-idle time** with `tready` tied high: `NSAMPLES`×2+3 cycles.

## Configuration
- **`SENSE_READER_LEADONE_EN` defined:** the encoder outputs the count of consecutive ones starting at bit 0, stopping at the first zero, instead of the popcount. This gives true edge position, but it is not bubble-tolerant. The latency of 2 is unchanged.
- **Undefined (default):** popcount encoding as above.

## Test plan
- **Reset idle:** reset, then 10 idle cycles with `trigin`=0 → `tvalid`=0, `busyout`=0, `tdata`=0x00 throughout.
- **Thermometer ramp:**
  - Stimulus: `NSAMPLES`=4, `valin` sequence 0x0, 0xFF, 0xFFFF_FFFF, all-ones, `tready`=1.
  - Required: bytes 0x00, 0x08, 0x20, 0x40 in order, on consecutive cycles.
- **Backpressure:**
  - Stimulus: `tready` toggled 1,0,0,1,… during drain.
  - Required: `tdata` stable while `tvalid`=1 and `tready`=0, with no byte lost or duplicated.
- **Bubble:**
  - Stimulus: `valin`=0x0000_0000_0000_00F7.
  - Required: 0x07 by default; 0x03 with `SENSE_READER_LEADONE_EN`.
- **Trigger while busy:**
  - Stimulus: a `trigin` pulse mid-CAPTURE and mid-DRAIN.
  - Required: exactly `NSAMPLES` bytes emitted, and no second capture.
- **Reset mid-drain:**
  - Stimulus: `rstnin` pulsed low after 2 of 4 bytes.
  - Required: `tvalid` drops asynchronously and `busyout`=0. A following trigger yields a full fresh 4-byte capture.
